// File: rtl/timer_pkg.sv
// Shared definitions for the interval timer: interval codes and FSM state type.
package timer_pkg;

    localparam logic [1:0] BASE = 2'd0;
    localparam logic [1:0] EXTD = 2'd1;
    localparam logic [1:0] YELL = 2'd2;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StWait,
        StCount,
        StDone
    } state_t;

endpackage

// File: rtl/tick_divider.sv
// One-cycle tick strobe every CLK_DIV clk cycles, restartable by a synchronous clear.
module tick_divider #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic Reset,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CntW = $clog2(CLK_DIV);
    localparam logic [CntW-1:0] CntLast = CntW'(CLK_DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == CntLast);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/interval_timer.sv
// Interval timer: fetches a duration from the parameter store and counts it down in seconds.
// Optional macro TIMER_RESTART_EN lets Start_Timer restart a running countdown.
module interval_timer
    import timer_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       Start_Timer,
    input  logic [1:0] interval_req,
    input  logic       prog_active,
    input  logic [3:0] value,
    output logic [1:0] interval,
    output logic       busy,
    output logic       expired,
    output logic [3:0] remaining
);

    state_t     state_q, state_d;
    logic [1:0] interval_q, interval_d;
    logic [3:0] remaining_q, remaining_d;
    logic       tick;
    logic       div_clear;

    // Divider restarts on the load edge so the first tick lands CLK_DIV cycles later.
    assign div_clear = (state_q == StWait);

    tick_divider #(
        .CLK_DIV(CLK_DIV)
    ) u_tick_divider (
        .clk  (clk),
        .Reset(Reset),
        .clear(div_clear),
        .tick (tick)
    );

    always_comb begin
        state_d     = state_q;
        interval_d  = interval_q;
        remaining_d = remaining_q;
        case (state_q)
            StIdle: begin
                if (Start_Timer) begin
                    interval_d = interval_req;
                    state_d    = StFetch;
                end
            end
            StFetch: begin
                if (!prog_active) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                remaining_d = value;
                state_d     = StCount;
            end
            StCount: begin
`ifdef TIMER_RESTART_EN
                if (Start_Timer) begin
                    interval_d = interval_req;
                    state_d    = StFetch;
                end else
`endif
                if (remaining_q == 4'd0) begin
                    state_d = StDone;
                end else if (tick) begin
                    remaining_d = remaining_q - 4'd1;
                    if (remaining_q == 4'd1) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= StIdle;
            interval_q  <= BASE;
            remaining_q <= 4'd0;
        end else begin
            state_q     <= state_d;
            interval_q  <= interval_d;
            remaining_q <= remaining_d;
        end
    end

    assign interval  = interval_q;
    assign remaining = remaining_q;
    assign busy      = (state_q != StIdle);
    assign expired   = (state_q == StDone);

endmodule

// File: tb/tb_interval_timer.sv
// Self-checking bench for interval_timer: directed vector table, corner sequences and
// randomized traffic against a timestamp-based reference model.
module tb_interval_timer;

    localparam int CLK_DIV = 4;
    localparam int BIG = 1 << 30;

    logic       clk = 1'b0;
    logic       Reset;
    logic       Start_Timer;
    logic [1:0] interval_req;
    logic       prog_active;
    logic [3:0] value;
    logic [1:0] interval;
    logic       busy;
    logic       expired;
    logic [3:0] remaining;

    interval_timer #(
        .CLK_DIV(CLK_DIV)
    ) dut (
        .clk         (clk),
        .Reset       (Reset),
        .Start_Timer (Start_Timer),
        .interval_req(interval_req),
        .prog_active (prog_active),
        .value       (value),
        .interval    (interval),
        .busy        (busy),
        .expired     (expired),
        .remaining   (remaining)
    );

    always #5 clk = ~clk;

    // Parameter store: registered lookup, frozen while being programmed.
    logic [3:0] store_tbl [4];
    always @(posedge clk) begin
        if (!prog_active) value <= store_tbl[interval];
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: tracks when the interval loads and when it must expire, and derives
    // remaining from elapsed time since the load edge.
    int         ecyc     = 0;
    bit         m_active = 1'b0;
    bit         m_fetch  = 1'b0;
    int         m_load   = -1;
    int         m_exp    = -1;
    int         m_val    = 0;
    int         m_hold   = 0;
    int         m_prev   = 0;
    logic [1:0] m_int    = 2'd0;
    bit         model_on = 1'b0;

    function automatic int exp_rem();
        if (m_fetch || ecyc < m_load) return m_hold;
        if (ecyc >= m_exp) return 0;
        return m_val - (ecyc - m_load) / CLK_DIV;
    endfunction

    always @(posedge clk or posedge Reset) begin
        if (Reset) begin
            m_active = 1'b0;
            m_fetch  = 1'b0;
            m_load   = -1;
            m_exp    = -1;
            m_val    = 0;
            m_hold   = 0;
            m_int    = 2'd0;
        end else begin
            m_prev = exp_rem();
            ecyc++;
            if (m_active && ecyc == m_exp + 1) begin
                m_active = 1'b0;
            end else if (!m_active) begin
                if (Start_Timer) begin
                    m_active = 1'b1;
                    m_fetch  = 1'b1;
                    m_int    = interval_req;
                    m_hold   = m_prev;
                    m_load   = BIG;
                    m_exp    = BIG;
                end
            end else if (m_fetch) begin
                if (!prog_active) begin
                    m_fetch = 1'b0;
                    m_load  = ecyc + 1;
                    m_val   = int'(store_tbl[m_int]);
                    m_exp   = m_load + ((m_val == 0) ? 1 : CLK_DIV * m_val);
                end
            end
`ifdef TIMER_RESTART_EN
            else if (ecyc > m_load && ecyc <= m_exp && Start_Timer) begin
                m_fetch = 1'b1;
                m_int   = interval_req;
                m_hold  = m_prev;
                m_load  = BIG;
                m_exp   = BIG;
            end
`endif
        end
    end

    always @(negedge clk) begin
        logic [7:0] act_v, exp_v;
        if (model_on) begin
            act_v = {interval, remaining, busy, expired};
            exp_v = {m_int, 4'(exp_rem()), m_active, m_active && (ecyc == m_exp)};
            check("model_outputs", int'(act_v), int'(exp_v));
        end
    end

    typedef struct {
        logic [1:0] code;
        logic [3:0] val;
        int         prog;
        int         exp_n;
    } vec_t;

    vec_t vecs [6];

    task automatic wait_idle();
        int i = 0;
        while (busy && i < 200) begin
            @(negedge clk);
            i++;
        end
        if (busy) check("idle_timeout", int'(busy), 0);
        @(negedge clk);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        bit got = 1'b0;
        wait_idle();
        store_tbl[v.code] = v.val;
        @(negedge clk);
        Start_Timer  = 1'b1;
        interval_req = v.code;
        prog_active  = (v.prog != 0);
        for (int n = 0; n < 120 && !got; n++) begin
            @(posedge clk);
            #1;
            if (n == 0) begin
                Start_Timer = 1'b0;
                check({tag, "_interval"}, int'(interval), int'(v.code));
            end
            if (n == v.prog) prog_active = 1'b0;
            if (n == v.prog + 2) check({tag, "_load"}, int'(remaining), int'(v.val));
            if (expired) begin
                got = 1'b1;
                check({tag, "_expire_edge"}, n, v.exp_n);
                @(posedge clk);
                #1;
                check({tag, "_idle_after"}, int'(busy), 0);
            end
        end
        if (!got) check({tag, "_timeout"}, 0, 1);
    endtask

    initial begin
        int first_exp;
        int seen;
        int pulses[$];

        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
        first_exp = 0; seen = 0; pulses.delete();
    end

    initial begin
        int first_exp;
        int seen;
        int pulses[$];

        // code, store value, programming edges after E0, expected expire edge
        vecs[0] = '{2'd0, 4'd6,  0, 26};
        vecs[1] = '{2'd2, 4'd2,  3, 13};
        vecs[2] = '{2'd2, 4'd2,  0, 10};
        vecs[3] = '{2'd1, 4'd0,  0, 3};
        vecs[4] = '{2'd3, 4'd15, 0, 62};
        vecs[5] = '{2'd1, 4'd1,  1, 7};

        Reset        = 1'b1;
        Start_Timer  = 1'b0;
        interval_req = 2'd0;
        prog_active  = 1'b0;
        store_tbl    = '{4'd5, 4'd3, 4'd2, 4'd15};
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", int'(busy), 0);
        check("reset_expired", int'(expired), 0);
        check("reset_remaining", int'(remaining), 0);
        check("reset_interval", int'(interval), 0);
        Reset    = 1'b0;
        model_on = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Restart during COUNT.
        wait_idle();
        store_tbl[0] = 4'd6;
        store_tbl[1] = 4'd3;
        @(negedge clk);
        Start_Timer  = 1'b1;
        interval_req = 2'd0;
        first_exp    = -1;
        for (int n = 0; n < 100; n++) begin
            @(posedge clk);
            #1;
            if (n == 0) Start_Timer = 1'b0;
            if (n == 8) begin
                Start_Timer  = 1'b1;
                interval_req = 2'd1;
            end
            if (n == 9) Start_Timer = 1'b0;
            if (expired) begin
                first_exp = n;
                break;
            end
        end
`ifdef TIMER_RESTART_EN
        check("restart_expire_edge", first_exp, 23);
        check("restart_interval", int'(interval), 1);
`else
        check("restart_ignored_edge", first_exp, 26);
        check("restart_ignored_interval", int'(interval), 0);
`endif

        // Asynchronous reset mid-count with remaining=3.
        wait_idle();
        store_tbl[0] = 4'd6;
        @(negedge clk);
        Start_Timer  = 1'b1;
        interval_req = 2'd0;
        for (int n = 0; n < 16; n++) begin
            @(posedge clk);
            #1;
            if (n == 0) Start_Timer = 1'b0;
        end
        check("pre_reset_remaining", int'(remaining), 3);
        #2;
        Reset = 1'b1;
        #1;
        check("async_reset_busy", int'(busy), 0);
        check("async_reset_expired", int'(expired), 0);
        check("async_reset_remaining", int'(remaining), 0);
        check("async_reset_interval", int'(interval), 0);
        @(negedge clk);
        Reset = 1'b0;
        seen  = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (expired) seen++;
        end
        check("no_expire_after_reset", seen, 0);
        run_vec(vecs[0], "post_reset");

        // Start_Timer held high: one interval per pass through IDLE.
        wait_idle();
        store_tbl[2] = 4'd2;
        @(negedge clk);
        Start_Timer  = 1'b1;
        interval_req = 2'd2;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk);
            #1;
            if (expired) pulses.push_back(n);
        end
        Start_Timer = 1'b0;
        check("held_pulse_count", pulses.size(), 3);
        if (pulses.size() >= 3) begin
            check("held_first_expire", pulses[0], 10);
            check("held_spacing_1", pulses[1] - pulses[0], 12);
            check("held_spacing_2", pulses[2] - pulses[1], 12);
        end

        // Randomized traffic, checked every cycle by the model.
        wait_idle();
        for (int i = 0; i < 4; i++) store_tbl[i] = 4'($urandom_range(0, 15));
        repeat (2500) begin
            @(negedge clk);
            Start_Timer  = ($urandom_range(0, 7) == 0);
            interval_req = 2'($urandom_range(0, 3));
            prog_active  = ($urandom_range(0, 3) == 0);
        end
        @(negedge clk);
        Start_Timer = 1'b0;
        prog_active = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
        first_exp = 0; seen = 0;
    end

endmodule

// File: doc/interval_timer.md
INTERVAL_TIMER -- requirements
Module: interval_timer

Interface
REQ-001 Parameter CLK_DIV, default 4: clk cycles per one-second tick, at least 2.
REQ-002 clk  in  1  system clock, all state on rising edge.
REQ-003 Reset  in  1  asynchronous, active-high reset.
REQ-004 Start_Timer  in  1  level request to time one interval, sampled on clk.
REQ-005 interval_req  in  2  interval code to time: 0 base, 1 extended, 2 yellow, 3 undefined.
REQ-006 prog_active  in  1  high while the parameter store is being programmed, so its value output is frozen.
REQ-007 value  in  4  duration in seconds returned by the parameter store, one registered cycle after interval.
REQ-008 interval  out  2  registered interval code driven to the parameter store.
REQ-009 busy  out  1  high in every state except IDLE.
REQ-010 expired  out  1  one-cycle pulse when the interval ends.
REQ-011 remaining  out  4  current countdown value, 0 when idle.

Function
REQ-012 FSM states: IDLE, FETCH, WAIT, COUNT, DONE.
REQ-013 IDLE: when Start_Timer=1 on an edge, latch interval_req into interval and go to FETCH.
REQ-014 FETCH: stay while prog_active=1; go to WAIT on the first edge with prog_active=0, giving the store one clean edge to refresh value.
REQ-015 WAIT: on the next edge, load remaining from value, clear the tick divider and go to COUNT.
REQ-016 Tick: a one-cycle strobe every CLK_DIV clk cycles after the divider clears; first tick is exactly CLK_DIV cycles after the load edge.
REQ-017 COUNT: decrement remaining on each tick; on the tick where remaining=1, set remaining to 0 and go to DONE.
REQ-018 A loaded value of 0 goes to DONE on the next edge without waiting for a tick.
REQ-019 Code 3 is timed normally using whatever value the store returns (15).
REQ-020 DONE: expired=1 for exactly this one cycle, then IDLE; Start_Timer is not accepted in DONE.
REQ-021 Start_Timer in FETCH, WAIT or COUNT is ignored, except as stated in REQ-025.
REQ-022 interval holds its value until the next accepted start.
REQ-023 prog_active in WAIT or COUNT is ignored; the loaded duration is kept.

Reset
REQ-024 Reset forces, asynchronously and mid-operation: state IDLE, interval=0, remaining=0, divider=0, busy=0, expired=0; no expired pulse for an aborted interval.

Configuration
REQ-025 Macro TIMER_RESTART_EN.
- Defined: Start_Timer=1 in COUNT latches interval_req and goes to FETCH with no expired pulse.
- Undefined: Start_Timer is ignored in COUNT.

Structure
REQ-026 Shared package timer_pkg holds the interval codes (BASE=0, EXTD=1, YELL=2) and the state enum type.
REQ-027 The tick divider is a sub-module, tick_divider, with inputs clk, Reset, clear and output tick.

Verification
All scenarios use CLK_DIV=4; edge E0 is the edge on which Start_Timer is accepted.
REQ-028 Start, code 0, store value 6 -> interval=0 after E0; remaining=6 after E2; expired high from E26 to E27; busy low after E27.
REQ-029 Start, code 2, value 2, prog_active held high for 3 edges after E0 -> WAIT delayed by 3 edges; expired pulse 3 cycles later than the no-program case.
REQ-030 Start, value 0 -> expired pulses on the edge after load; no tick required.
REQ-031 Reset asserted mid-count with remaining=3 -> all outputs 0 immediately; no expired pulse; a new start works normally.
REQ-032 With TIMER_RESTART_EN: restart in COUNT with code 1, value 3 -> no pulse for the first interval; expired 14 cycles after the restart edge. Without the macro: restart ignored, original interval completes.
REQ-033 Start_Timer held high continuously -> one interval per pass through IDLE; expired pulses spaced by duration plus fixed overhead, with no start taken in DONE.
